// File: rtl/data_ram_slave.sv
// Single-port doubleword RAM behind an AHB-style slave interface.
// Adds configurable wait states, byte-lane writes and error responses for misaligned or out-of-range accesses.
module data_ram_slave #(
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, LAST, ERR} state_t;

  state_t          state, state_n;
  logic [2:0]      cnt, cnt_n;
  logic [AW-1:0]   idx_q;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            write_q;
  logic            err_q;
  logic            accept;
  logic            misaligned;
  logic            req_err;
  logic [7:0]      lane_mask;
  logic [63:0]     bit_mask;
  logic [63:0]     mem [DEPTH];

  // Out of range is any set bit above the doubleword index, since DEPTH is a power of two.
  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      2'd1:    misaligned = HADDR[0];
      2'd2:    misaligned = |HADDR[1:0];
      2'd3:    misaligned = |HADDR[2:0];
      default: misaligned = 1'b0;
    endcase
    req_err = misaligned | (|HADDR[63:AW+3]);
  end

  assign accept = HTRANS & HREADY;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = LAST;
      end
      ERR:     state_n = LAST;
      LAST:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (accept) begin
      if (req_err) begin
        state_n = ERR;
      end else if (WAIT_STATES > 0) begin
        state_n = WAIT;
        cnt_n   = 3'(WAIT_STATES);
      end else begin
        state_n = LAST;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q   <= HADDR[AW+2:3];
        off_q   <= HADDR[2:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
        err_q   <= req_err;
      end
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
    lane_mask = lane_mask << off_q;
    bit_mask  = '0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{lane_mask[b]}};
    end
  end

  // Array is deliberately not reset; reset forces IDLE so no commit can happen.
  always_ff @(posedge CLK) begin
    if (state == LAST && write_q && !err_q) begin
      mem[idx_q] <= (mem[idx_q] & ~bit_mask) | (HWDATA & bit_mask);
    end
  end

  assign HREADY = !(state == WAIT || state == ERR);
  assign HRESP  = err_q && (state == ERR || state == LAST);
  assign HRDATA = (state == LAST && !write_q && !err_q) ? mem[idx_q] : 64'd0;

endmodule

// File: tb/tb_data_ram_slave.sv
// Directed bench for data_ram_slave with three instances (0, 1 and 3 wait states) sharing the bus inputs.
// Each section drives the protocol against the selected instance's HREADY and checks only that instance.
module tb_data_ram_slave;

  logic        CLK;
  logic        RESET;
  logic        HTRANS;
  logic [63:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [63:0] HWDATA;

  logic [63:0] rdata_ws0, rdata_ws1, rdata_ws3;
  logic        ready_ws0, ready_ws1, ready_ws3;
  logic        resp_ws0, resp_ws1, resp_ws3;

  logic [63:0] rdata_sel;
  logic        ready_sel, resp_sel;
  int          sel = 1;

  int total = 0;
  int bad   = 0;

  data_ram_slave #(.DEPTH(512), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RESET(RESET), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(rdata_ws0), .HREADY(ready_ws0), .HRESP(resp_ws0));

  data_ram_slave #(.DEPTH(512), .WAIT_STATES(1)) u_ws1 (
    .CLK(CLK), .RESET(RESET), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(rdata_ws1), .HREADY(ready_ws1), .HRESP(resp_ws1));

  data_ram_slave #(.DEPTH(512), .WAIT_STATES(3)) u_ws3 (
    .CLK(CLK), .RESET(RESET), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(rdata_ws3), .HREADY(ready_ws3), .HRESP(resp_ws3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    case (sel)
      0:       begin rdata_sel = rdata_ws0; ready_sel = ready_ws0; resp_sel = resp_ws0; end
      3:       begin rdata_sel = rdata_ws3; ready_sel = ready_ws3; resp_sel = resp_ws3; end
      default: begin rdata_sel = rdata_ws1; ready_sel = ready_ws1; resp_sel = resp_ws1; end
    endcase
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ends at a falling edge with reset released, ready for an address phase.
  task automatic pulse_reset();
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Caller is at a falling edge with the selected slave idle; returns just after the edge ending the data phase.
  task automatic apply_stimulus(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                                input logic [63:0] wdata, output int nwait, output logic resp_wait,
                                output logic resp_last, output logic [63:0] rdata, output logic timeout);
    HTRANS = 1'b1;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    @(posedge CLK);
    #1;
    HTRANS    = 1'b0;
    HWDATA    = wdata;
    nwait     = 0;
    resp_wait = 1'b0;
    resp_last = 1'b0;
    rdata     = '0;
    timeout   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (ready_sel) begin
        resp_last = resp_sel;
        rdata     = rdata_sel;
        timeout   = 1'b0;
        break;
      end
      nwait++;
      resp_wait = resp_wait | resp_sel;
    end
    @(posedge CLK);
    #1;
    HWDATA = '0;
  endtask

  initial begin
    int          nw;
    logic        rw, rl, to;
    logic [63:0] rd;

    RESET  = 1'b0;
    HTRANS = 1'b0;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = 2'd0;
    HWDATA = '0;
    #1 RESET = 1'b1;
    #2;
    check_output("reset_hready", 64'(ready_ws1), 64'd1);
    check_output("reset_hresp",  64'(resp_ws1),  64'd0);
    check_output("reset_hrdata", rdata_ws1,      64'd0);

    // One wait state: dword write/read, byte merge, misaligned and out-of-range errors.
    sel = 1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    apply_stimulus(1'b1, 64'h10, 2'd3, 64'h1122334455667788, nw, rw, rl, rd, to);
    check_output("wr10_waits", 64'(nw), 64'd1);
    check_output("wr10_resp",  64'({rw, rl}), 64'd0);
    check_output("wr10_tmo",   64'(to), 64'd0);
    check_output("idle_hrdata", rdata_ws1, 64'd0);

    @(negedge CLK);
    apply_stimulus(1'b0, 64'h10, 2'd3, 64'd0, nw, rw, rl, rd, to);
    check_output("rd10_waits", 64'(nw), 64'd1);
    check_output("rd10_data",  rd, 64'h1122334455667788);
    check_output("rd10_resp",  64'({rw, rl}), 64'd0);

    @(negedge CLK);
    apply_stimulus(1'b1, 64'h13, 2'd0, 64'h00000000AB000000, nw, rw, rl, rd, to);
    check_output("wrb13_resp", 64'({rw, rl}), 64'd0);
    @(negedge CLK);
    apply_stimulus(1'b0, 64'h10, 2'd3, 64'd0, nw, rw, rl, rd, to);
    check_output("rd_after_byte", rd, 64'h11223344AB667788);

    @(negedge CLK);
    apply_stimulus(1'b1, 64'h11, 2'd1, 64'hFFFFFFFFFFFFFFFF, nw, rw, rl, rd, to);
    check_output("misal_waits",     64'(nw), 64'd1);
    check_output("misal_resp_wait", 64'(rw), 64'd1);
    check_output("misal_resp_last", 64'(rl), 64'd1);
    @(negedge CLK);
    apply_stimulus(1'b0, 64'h10, 2'd3, 64'd0, nw, rw, rl, rd, to);
    check_output("rd_after_misal", rd, 64'h11223344AB667788);

    @(negedge CLK);
    apply_stimulus(1'b0, 64'h1000, 2'd3, 64'd0, nw, rw, rl, rd, to);
    check_output("oor_waits", 64'(nw), 64'd1);
    check_output("oor_resp",  64'({rw, rl}), 64'd3);
    check_output("oor_data",  rd, 64'd0);

    // Zero wait states: write then read issued back-to-back with no bubble.
    sel = 0;
    pulse_reset();
    HTRANS = 1'b1;
    HADDR  = 64'h20;
    HWRITE = 1'b1;
    HSIZE  = 2'd1;
    @(posedge CLK);
    #1;
    HWDATA = 64'h000000000000DEAD;
    HWRITE = 1'b0;
    HSIZE  = 2'd3;
    @(negedge CLK);
    check_output("b2b_wr_ready", 64'(ready_ws0), 64'd1);
    check_output("b2b_wr_resp",  64'(resp_ws0),  64'd0);
    @(posedge CLK);
    #1;
    HTRANS = 1'b0;
    HWDATA = '0;
    @(negedge CLK);
    check_output("b2b_rd_ready", 64'(ready_ws0), 64'd1);
    check_output("b2b_rd_low",   64'(rdata_ws0[15:0]), 64'h000000000000DEAD);
    check_output("b2b_rd_resp",  64'(resp_ws0), 64'd0);
    @(negedge CLK);
    check_output("b2b_idle_data", rdata_ws0, 64'd0);

    // Three wait states: reset mid-write must leave the stored doubleword intact.
    sel = 3;
    pulse_reset();
    apply_stimulus(1'b1, 64'h8, 2'd3, 64'h0123456789ABCDEF, nw, rw, rl, rd, to);
    check_output("ws3_wr_waits", 64'(nw), 64'd3);
    @(negedge CLK);
    HTRANS = 1'b1;
    HADDR  = 64'h8;
    HWRITE = 1'b1;
    HSIZE  = 2'd3;
    @(posedge CLK);
    #1;
    HTRANS = 1'b0;
    HWDATA = 64'hFFFFFFFFFFFFFFFF;
    @(negedge CLK);
    check_output("ws3_in_wait", 64'(ready_ws3), 64'd0);
    #1 RESET = 1'b1;
    #1;
    check_output("midrst_hready", 64'(ready_ws3), 64'd1);
    check_output("midrst_hresp",  64'(resp_ws3),  64'd0);
    check_output("midrst_hrdata", rdata_ws3,      64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET  = 1'b0;
    HWDATA = '0;
    apply_stimulus(1'b0, 64'h8, 2'd3, 64'd0, nw, rw, rl, rd, to);
    check_output("ws3_rd_waits", 64'(nw), 64'd3);
    check_output("ws3_rd_data",  rd, 64'h0123456789ABCDEF);
    check_output("ws3_rd_tmo",   64'(to), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
